// File: rtl/traffic_request_arbiter.sv
// Fixed-priority arbiter that latches intersection service requests and offers them one at a time.
// Optional pedestrian rate limiting is compiled in with `define PED_COOLDOWN_EN.
module traffic_request_arbiter #(
    parameter int unsigned COOLDOWN_CYCLES = 100000000,
    parameter int unsigned CNT_W           = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       emergency_in,
    input  logic       power_outage_in,
    input  logic       pedestrian_in,
    input  logic       left_turn_in,
    input  logic       ctrl_ready,
    input  logic       grant_ack,
    output logic       grant_valid,
    output logic [1:0] grant_id,
    output logic [3:0] pending,
    output logic       busy
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_OFFER   = 2'd1;
    localparam logic [1:0] ST_SERVICE = 2'd2;

    if (CNT_W < 32 && COOLDOWN_CYCLES >= (32'd1 << CNT_W)) begin : g_bad_cnt_w
        $error("CNT_W too narrow for COOLDOWN_CYCLES");
    end

    logic [3:0] raw;
    logic [3:0] sync1;
    logic [3:0] sync2;
    logic [1:0] fill;
    // Edge-detected inputs, bit order: 0 = emergency, 1 = pedestrian, 2 = left turn.
    logic [2:0] ev_sync;
    logic [2:0] edge_q;
    logic [2:0] armed;
    logic [2:0] rise;
    logic [2:0] pend_q;
    logic       served;
    logic [1:0] state;
    logic       seen_low;
    logic       ack_fire;
    logic [3:0] eligible;
    logic [1:0] sel_id;

    assign raw     = {left_turn_in, pedestrian_in, power_outage_in, emergency_in};
    assign ev_sync = {sync2[3], sync2[2], sync2[0]};
    assign rise    = ev_sync & ~edge_q & armed;
    assign ack_fire = (state == ST_OFFER) && grant_ack;
    assign pending = {pend_q[2], pend_q[1], sync2[1] & ~served, pend_q[0]};

    // An input only arms once it has been observed low through a filled synchronizer,
    // so a level already high when reset is released never counts as an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1  <= '0;
            sync2  <= '0;
            fill   <= '0;
            edge_q <= '0;
            armed  <= '0;
        end else begin
            sync1  <= raw;
            sync2  <= sync1;
            fill   <= {fill[0], 1'b1};
            edge_q <= ev_sync;
            armed  <= armed | ({3{fill[1]}} & ~ev_sync);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
            served <= 1'b0;
        end else begin
            pend_q[0] <= rise[0] | (pend_q[0] & ~(ack_fire && grant_id == 2'd0));
            pend_q[1] <= rise[1] | (pend_q[1] & ~(ack_fire && grant_id == 2'd2));
            pend_q[2] <= rise[2] | (pend_q[2] & ~(ack_fire && grant_id == 2'd3));
            if (!sync2[1])
                served <= 1'b0;
            else if (ack_fire && grant_id == 2'd1)
                served <= 1'b1;
        end
    end

`ifdef PED_COOLDOWN_EN
    localparam logic [CNT_W-1:0] COOLDOWN_LOAD = CNT_W'(COOLDOWN_CYCLES);
    logic [CNT_W-1:0] cd_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cd_cnt <= '0;
        else if (ack_fire && grant_id == 2'd2)
            cd_cnt <= COOLDOWN_LOAD;
        else if (cd_cnt != '0)
            cd_cnt <= cd_cnt - CNT_W'(1);
    end

    assign eligible = pending & ~{1'b0, (cd_cnt != '0), 2'b00};
`else
    assign eligible = pending;
`endif

    always_comb begin
        sel_id = 2'd3;
        if (eligible[0])
            sel_id = 2'd0;
        else if (eligible[1])
            sel_id = 2'd1;
        else if (eligible[2])
            sel_id = 2'd2;
    end

    // Handshake: grant_valid/grant_id are held stable from the offer until grant_ack is
    // sampled high on a clock edge; that single edge completes the transfer, there is no
    // preemption, and grant_ack outside an offer has no effect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            grant_valid <= 1'b0;
            grant_id    <= 2'd0;
            busy        <= 1'b0;
            seen_low    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (ctrl_ready && (eligible != 4'b0000)) begin
                        grant_id    <= sel_id;
                        grant_valid <= 1'b1;
                        state       <= ST_OFFER;
                    end
                end
                ST_OFFER: begin
                    if (grant_ack) begin
                        grant_valid <= 1'b0;
                        busy        <= 1'b1;
                        seen_low    <= 1'b0;
                        state       <= ST_SERVICE;
                    end
                end
                ST_SERVICE: begin
                    // Sequencer must leave its ready phase and come back before a regrant.
                    if (!ctrl_ready) begin
                        seen_low <= 1'b1;
                    end else if (seen_low) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    grant_valid <= 1'b0;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_traffic_request_arbiter.sv
// Self-checking bench for traffic_request_arbiter; grant ids are scoreboarded in request order.
module tb_traffic_request_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic       ctrl_ready;
    logic       grant_ack;
    logic       grant_valid;
    logic [1:0] grant_id;
    logic [3:0] pending;
    logic       busy;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned cyc      = 0;
    int unsigned ack_cyc  = 0;
    logic [1:0]  exp_q[$];

    traffic_request_arbiter #(.COOLDOWN_CYCLES(20), .CNT_W(8)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .emergency_in    (req[0]),
        .power_outage_in (req[1]),
        .pedestrian_in   (req[2]),
        .left_turn_in    (req[3]),
        .ctrl_ready      (ctrl_ready),
        .grant_ack       (grant_ack),
        .grant_valid     (grant_valid),
        .grant_id        (grant_id),
        .pending         (pending),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic press(input int idx);
        req[idx] = 1'b1;
        tick();
        tick();
        req[idx] = 1'b0;
    endtask

    task automatic wait_grant(input int budget);
        logic [1:0] exp_id;
        int n = 0;
        while (!grant_valid && n < budget) begin
            tick();
            n++;
        end
        if (!grant_valid)
            check("grant_timeout", 32'd0, 32'd1);
        else if (exp_q.size() == 0)
            check("grant_unexpected", {30'd0, grant_id}, 32'hffff_ffff);
        else begin
            exp_id = exp_q.pop_front();
            check("grant_id", {30'd0, grant_id}, {30'd0, exp_id});
        end
    endtask

    task automatic ack_grant();
        grant_ack = 1'b1;
        tick();
        grant_ack = 1'b0;
        check("ack_valid_low", {31'd0, grant_valid}, 32'd0);
        check("ack_busy_high", {31'd0, busy}, 32'd1);
    endtask

    task automatic ready_cycle();
        ctrl_ready = 1'b0;
        tick();
        ctrl_ready = 1'b1;
        tick();
        check("service_done", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic seen;
        rst_n      = 1'b0;
        req        = 4'b0000;
        ctrl_ready = 1'b1;
        grant_ack  = 1'b0;
        tick();
        tick();
        check("rst_valid", {31'd0, grant_valid}, 32'd0);
        check("rst_id", {30'd0, grant_id}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_pending", {28'd0, pending}, 32'd0);
        rst_n = 1'b1;
        repeat (5) tick();

        // Pedestrian pulse: pending after 3 edges, grant one cycle later.
        req[2] = 1'b1;
        tick();
        tick();
        req[2] = 1'b0;
        tick();
        check("ped_pending", {28'd0, pending}, 32'h4);
        check("ped_not_yet", {31'd0, grant_valid}, 32'd0);
        exp_q.push_back(2'd2);
        tick();
        check("ped_valid", {31'd0, grant_valid}, 32'd1);
        wait_grant(1);
        ack_grant();
        check("ped_cleared", {28'd0, pending}, 32'd0);
        ready_cycle();

        // Ack outside an offer is ignored.
        grant_ack = 1'b1;
        tick();
        grant_ack = 1'b0;
        check("stray_ack_busy", {31'd0, busy}, 32'd0);
        check("stray_ack_valid", {31'd0, grant_valid}, 32'd0);

        // Simultaneous emergency + left turn, then emergency during the left-turn offer.
        req[0] = 1'b1;
        req[3] = 1'b1;
        exp_q.push_back(2'd0);
        exp_q.push_back(2'd3);
        tick();
        tick();
        req = 4'b0000;
        wait_grant(10);
        ack_grant();
        ready_cycle();
        wait_grant(2);
        press(0);
        exp_q.push_back(2'd0);
        repeat (3) tick();
        check("hold_valid", {31'd0, grant_valid}, 32'd1);
        check("hold_id", {30'd0, grant_id}, 32'd3);
        check("hold_em_pending", {31'd0, pending[0]}, 32'd1);
        ack_grant();
        check("after_lt_pending", {28'd0, pending}, 32'h1);
        ready_cycle();
        wait_grant(2);
        ack_grant();
        ready_cycle();

        // Power outage: level-based, served once per high period.
        req[1] = 1'b1;
        exp_q.push_back(2'd1);
        wait_grant(10);
        ack_grant();
        check("outage_served", {31'd0, pending[1]}, 32'd0);
        ready_cycle();
        seen = 1'b0;
        repeat (10) begin
            tick();
            if (grant_valid) seen = 1'b1;
        end
        check("outage_no_regrant", {31'd0, seen}, 32'd0);
        req[1] = 1'b0;
        repeat (4) tick();
        req[1] = 1'b1;
        exp_q.push_back(2'd1);
        wait_grant(10);
        ack_grant();
        ready_cycle();
        req[1] = 1'b0;
        repeat (4) tick();

        // Pedestrian re-press shortly after an acked pedestrian grant.
        press(2);
        exp_q.push_back(2'd2);
        wait_grant(10);
        ack_grant();
        ack_cyc = cyc;
        ready_cycle();
        tick();
        press(2);
        repeat (3) tick();
        exp_q.push_back(2'd2);
`ifdef PED_COOLDOWN_EN
        check("cd_pending", {31'd0, pending[2]}, 32'd1);
        check("cd_blocked", {31'd0, grant_valid}, 32'd0);
        wait_grant(40);
        check("cd_latency_ge_20", {31'd0, (cyc - ack_cyc) >= 20}, 32'd1);
`else
        wait_grant(10);
        check("ped_latency_le_12", {31'd0, (cyc - ack_cyc) <= 12}, 32'd1);
`endif
        ack_grant();
        ready_cycle();

        // Reset during an offer.
        press(3);
        exp_q.push_back(2'd3);
        wait_grant(10);
        rst_n = 1'b0;
        #1;
        check("midrst_valid", {31'd0, grant_valid}, 32'd0);
        check("midrst_id", {30'd0, grant_id}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_pending", {28'd0, pending}, 32'd0);
        tick();
        rst_n = 1'b1;
        repeat (5) tick();
        press(2);
        exp_q.push_back(2'd2);
        wait_grant(10);
        ack_grant();
        ready_cycle();

        check("queue_empty", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/traffic_request_arbiter.md
# traffic_request_arbiter

Collects the asynchronous intersection service requests (emergency, power outage, pedestrian, left turn) and presents them to the traffic-light sequencer one at a time. It uses a fixed-priority valid/ack grant handshake. The block sits between the pushbutton/sensor inputs and the light sequencer. It synchronizes and latches requests so none are lost while the sequencer is busy, and it rate-limits pedestrian service.

## Interface
- COOLDOWN_CYCLES, 100000000: minimum clk cycles between an acked pedestrian grant and the next pedestrian grant (PED_COOLDOWN_EN only)
- CNT_W, 32: cooldown counter width; must hold COOLDOWN_CYCLES
- clk  input  1  system clock; all state on posedge
- rst_n  input  1  asynchronous, active-low reset
- emergency_in  input  1  raw emergency request, asynchronous
- power_outage_in  input  1  raw outage level, asynchronous
- pedestrian_in  input  1  raw pedestrian button, asynchronous
- left_turn_in  input  1  raw left-turn sensor, asynchronous
- ctrl_ready  input  1  sequencer is in a normal green phase and can accept a service request
- grant_ack  input  1  sequencer accepts the current grant
- grant_valid  output  1  grant offered
- grant_id  output  2  0 = emergency, 1 = power outage, 2 = pedestrian, 3 = left turn
- pending  output  4  latched requests, bit index = grant_id
- busy  output  1  a grant is acked and in service

## Operation
- Each raw input passes through a 2-flop synchronizer. Emergency, pedestrian and left turn are then rising-edge detected by one further register.
- pending[0], [2] and [3]:
  - set on a detected rising edge of their input
  - cleared only in the cycle the matching grant is acked
  - set wins over clear on the same cycle
- pending[1] = outage_sync & ~outage_served:
  - outage_served sets when grant id 1 is acked
  - outage_served clears when outage_sync is low
- Eligible set = pending. Under PED_COOLDOWN_EN, bit 2 is masked while the cooldown counter is nonzero. Priority is fixed: 0 > 1 > 2 > 3.
- FSM has three states:
  - IDLE: if ctrl_ready and the eligible set is nonzero, latch the highest-priority id into grant_id, assert grant_valid, go to OFFER.
  - OFFER: grant_valid and grant_id stay stable until grant_ack is sampled high. There is no preemption, even if a higher-priority request arrives. On ack, clear or serve the pending bit, deassert grant_valid, assert busy, go to SERVICE.
  - SERVICE: wait for ctrl_ready to be low for at least one cycle, then high again. On the ready rising edge, deassert busy and go to IDLE. This prevents an immediate regrant while the sequencer has not yet left its ready phase.
- grant_ack outside OFFER is ignored.
- Reset (any time, including mid-handshake):
  - grant_valid = 0, grant_id = 0, busy = 0, pending = 0
  - synchronizers, edge registers, outage_served and cooldown counter cleared
  - state IDLE
- After reset is released, an input already high does not produce an edge until it goes low and high again. Exception: power outage, being level-based, becomes pending after synchronization.

## Timing
- Raw edge to pending bit high: 3 clk edges (2 sync + edge register). Power outage: 2 edges.
- pending/eligible to grant_valid: 1 cycle, provided IDLE and ctrl_ready.
- Ack handshake:
  - ack sampled at posedge with grant_valid high
  - grant_valid low, busy high and pending bit cleared in the same next-state update, i.e. visible 1 cycle after the ack edge
  - a single-cycle ack is sufficient
- Back-to-back: the earliest next grant_valid is 1 cycle after the ctrl_ready rising edge ends SERVICE.
- Simultaneous edges on several inputs all latch. They are then served in priority order, one per handshake.

## Configuration
- PED_COOLDOWN_EN defined:
  - CNT_W counter loads COOLDOWN_CYCLES when a pedestrian grant is acked, and decrements to 0 once per clk
  - pending[2] may still latch during cooldown but is not eligible until the counter is 0
  - other ids are unaffected
- PED_COOLDOWN_EN undefined: no counter is instantiated; pending[2] is always eligible.

## Test plan
- Reset, then pulse pedestrian_in with ctrl_ready = 1 -> pending = 4'b0100 after 3 clk; grant_valid = 1, grant_id = 2 on the next cycle. Ack for 1 cycle -> grant_valid = 0, busy = 1, pending = 0.
- Pulse left_turn_in and emergency_in in the same cycle -> grant_id = 0 first. After ack, ctrl_ready low then high -> grant_id = 3.
- Raise emergency_in while OFFER holds grant_id = 3 -> grant_id stays 3 until ack. Emergency is granted next, with pending[0] = 1 throughout.
- Hold power_outage_in high -> grant_id = 1 once. After ack and a ctrl_ready cycle, no regrant while still high. Drop, then raise again -> granted again.
- PED_COOLDOWN_EN with COOLDOWN_CYCLES = 20: ack a pedestrian grant, re-press at cycle 5 -> pending[2] = 1 but no grant until the counter reaches 0. Without the macro -> granted at the first IDLE with ctrl_ready.
- Assert rst_n low during OFFER -> all outputs 0 immediately. After release, the next pedestrian pulse is granted normally.
